// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential Booth multiplier.
//   booth_state_t : FSM states (IDLE, CALC, DONE)
//   booth_op_t    : action selected by the Booth bit pair {Q[0], q_m1}
//   booth_cnt_w   : iteration counter width for a given operand width
//   booth_decode  : bit pair -> action
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_t;

    // Counter must reach WIDTH+1, so it needs room for WIDTH+2 values.
    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: operand/result handshake bundle of the Booth multiplier.
//   start_valid_in/start_ready_out + operands : operand handshake
//   done_valid_out/done_ready_in + product_out: result handshake
//   busy_out, count_out                       : status
// master = producer/consumer side, slave = multiplier side.
interface booth_seq_mult_if import booth_pkg::*; #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = booth_cnt_w(WIDTH);

    logic                 start_valid_in;
    logic                 start_ready_out;
    logic [WIDTH-1:0]     multiplicand_in;
    logic [WIDTH-1:0]     multiplier_in;
    logic                 signed_in;
    logic [2*WIDTH-1:0]   product_out;
    logic                 done_valid_out;
    logic                 done_ready_in;
    logic                 busy_out;
    logic [CNT_W-1:0]     count_out;

    modport master (
        output start_valid_in, multiplicand_in, multiplier_in, signed_in, done_ready_in,
        input  start_ready_out, product_out, done_valid_out, busy_out, count_out
    );

    modport slave (
        input  start_valid_in, multiplicand_in, multiplier_in, signed_in, done_ready_in,
        output start_ready_out, product_out, done_valid_out, busy_out, count_out
    );
endinterface

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration on WIDTH+1 bit registers.
//   acc_in, q_in, qm1_in, m_in : current Acc, Q, q_m1 and multiplicand M
//   acc_out, q_out, qm1_out    : values after add/sub and arithmetic shift right
module booth_step import booth_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] acc_in,
    input  logic [WIDTH:0] q_in,
    input  logic           qm1_in,
    input  logic [WIDTH:0] m_in,
    output logic [WIDTH:0] acc_out,
    output logic [WIDTH:0] q_out,
    output logic           qm1_out
);
    logic [WIDTH:0] sum;

    always_comb begin
        case (booth_decode(q_in[0], qm1_in))
            BOOTH_ADD: sum = acc_in + m_in;
            BOOTH_SUB: sum = acc_in - m_in;
            default:   sum = acc_in;
        endcase
        // Arithmetic shift of {sum, Q, q_m1} right by one.
        acc_out = {sum[WIDTH], sum[WIDTH:1]};
        q_out   = {sum[0], q_in[WIDTH:1]};
        qm1_out = q_in[0];
    end
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier, signed or unsigned per op.
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : booth_seq_mult_if.slave (operand handshake, result handshake,
//              busy_out, count_out)
// Operands are extended to WIDTH+1 bits so one datapath serves both signednesses;
// WIDTH+1 iterations then yield the product in the low 2*WIDTH bits of {Acc, Q}.
// Optional: define BOOTH_EARLY_TERM_EN to finish as soon as the remaining
// iterations would all be shift-only.
module booth_seq_mult import booth_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    booth_seq_mult_if.slave  bus
);
    localparam int CNT_W = booth_cnt_w(WIDTH);
    localparam int EW    = WIDTH + 1;
    localparam int PW    = 2 * WIDTH;

    booth_state_t   state_r, state_nx;
    logic [EW-1:0]  m_r, acc_r, q_r;
    logic           qm1_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PW-1:0]  prod_r;

    logic [EW-1:0]  acc_nx, q_nx, a_ext, b_ext;
    logic           qm1_nx, last_iter, early;
    logic [PW-1:0]  early_prod;

    assign a_ext     = {bus.signed_in & bus.multiplicand_in[WIDTH-1], bus.multiplicand_in};
    assign b_ext     = {bus.signed_in & bus.multiplier_in[WIDTH-1], bus.multiplier_in};
    assign last_iter = (cnt_r == CNT_W'(WIDTH));

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc_r),
        .q_in    (q_r),
        .qm1_in  (qm1_r),
        .m_in    (m_r),
        .acc_out (acc_nx),
        .q_out   (q_nx),
        .qm1_out (qm1_nx)
    );

`ifdef BOOTH_EARLY_TERM_EN
    // Unprocessed multiplier bits are Q[WIDTH-cnt:0]; if they and q_m1 all agree,
    // every remaining pair is 00/11 and only the shifts are left to do.
    logic [EW-1:0] pend_mask;
    always_comb begin
        pend_mask  = {EW{1'b1}} >> cnt_r;
        early      = (((q_r ^ {EW{qm1_r}}) & pend_mask) == '0);
        early_prod = PW'($signed({acc_r, q_r}) >>> (CNT_W'(EW) - cnt_r));
    end
`else
    assign early      = 1'b0;
    assign early_prod = '0;
`endif

    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (bus.start_valid_in)      state_nx = CALC;
            CALC:    if (early || last_iter)      state_nx = DONE;
            DONE:    if (bus.done_ready_in)       state_nx = IDLE;
            default:                              state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_r <= IDLE;
        else           state_r <= state_nx;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_r    <= '0;
            acc_r  <= '0;
            q_r    <= '0;
            qm1_r  <= 1'b0;
            cnt_r  <= '0;
            prod_r <= '0;
        end else begin
            case (state_r)
                IDLE: if (bus.start_valid_in) begin
                    m_r   <= a_ext;
                    q_r   <= b_ext;
                    acc_r <= '0;
                    qm1_r <= 1'b0;
                    cnt_r <= '0;
                end
                CALC: if (early) begin
                    prod_r <= early_prod;
                end else begin
                    acc_r <= acc_nx;
                    q_r   <= q_nx;
                    qm1_r <= qm1_nx;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_iter) prod_r <= {acc_nx[WIDTH-2:0], q_nx};
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready_out = (state_r == IDLE);
    assign bus.done_valid_out  = (state_r == DONE);
    assign bus.busy_out        = (state_r == CALC) || (state_r == DONE);
    assign bus.count_out       = cnt_r;
    assign bus.product_out     = prod_r;
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: table vectors, stall/reset/back-to-back sequences and random
// ops against booth_seq_mult (WIDTH=8). Expected products go into a queue when an
// operation is accepted and are compared when the result handshake happens.
module tb_booth_seq_mult;
    import booth_pkg::*;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    booth_seq_mult_if #(.WIDTH(W)) bus();
    booth_seq_mult #(.WIDTH(W)) dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [PW-1:0] p;
    } vec_t;

    int            n_chk = 0, n_fail = 0;
    int            cyc = 0;
    int            n_res = 0;
    int            last_lat = 0;
    bit            lat_check = 1'b0;
    logic [PW-1:0] exp_q[$];
    int            t_q[$];
    logic [PW-1:0] mon_e;
    int            mon_t;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint expv);
        n_chk++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        return PW'(sa * sb);
    endfunction

    // Result monitor: the handshake completes at the next rising edge.
    always @(negedge clk_in) begin
        if (rst_n_in && bus.done_valid_out && bus.done_ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_t    = t_q.pop_front();
                last_lat = cyc + 1 - mon_t;
                n_res++;
                chk("product", bus.product_out, mon_e);
`ifndef BOOTH_EARLY_TERM_EN
                if (lat_check) chk("latency_edges", last_lat, 10);
`endif
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the acceptance edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [PW-1:0] p, output int t_acc);
        bit ok = 1'b0;
        t_acc = -1;
        bus.multiplicand_in = a;
        bus.multiplier_in   = b;
        bus.signed_in       = s;
        bus.start_valid_in  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_in);
            if (bus.start_ready_out) begin
                ok    = 1'b1;
                t_acc = cyc + 1;
                exp_q.push_back(p);
                t_q.push_back(t_acc);
            end
            @(posedge clk_in); #1;
        end
        bus.start_valid_in = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk_in); #1;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    vec_t          tbl[9];
    int            t0, t1, res0;
    logic [PW-1:0] held;
    logic [W-1:0]  ra, rb;
    logic          rs;
    bit            seen;

    initial begin
        tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        tbl[3] = '{8'h07, 8'h06, 1'b0, 16'h002A};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 16'h0000};
        tbl[5] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        tbl[6] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
        tbl[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[8] = '{8'h01, 8'h80, 1'b1, 16'hFF80};

        bus.start_valid_in  = 1'b0;
        bus.multiplicand_in = '0;
        bus.multiplier_in   = '0;
        bus.signed_in       = 1'b0;
        bus.done_ready_in   = 1'b1;

        // Reset state
        #22;
        chk("rst_product", bus.product_out, 0);
        chk("rst_count", bus.count_out, 0);
        chk("rst_done_valid", bus.done_valid_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        #1 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        chk("start_ready_after_rst", bus.start_ready_out, 1);

        // Table vectors, one at a time, fixed latency checked by the monitor
        lat_check = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, t0);
            drain();
            if (i == 0) chk("count_after_255x255", bus.count_out, 9);
        end

        // Result stall: product held, no new acceptance
        lat_check = 1'b0;
        bus.done_ready_in = 1'b0;
        send(8'd200, 8'd3, 1'b0, 16'h0258, t0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done_valid_out) seen = 1'b1;
            else begin @(posedge clk_in); #1; end
        end
        chk("stall_done_seen", seen, 1);
        held = bus.product_out;
        chk("stall_product", held, 16'h0258);
        res0 = n_res;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.multiplicand_in = 8'h11;
                bus.multiplier_in   = 8'h22;
                bus.start_valid_in  = 1'b1;
            end
            if (i == 7) bus.start_valid_in = 1'b0;
            @(posedge clk_in); #1;
            chk("stall_product_stable", bus.product_out, held);
            chk("stall_start_ready", bus.start_ready_out, 0);
            chk("stall_done_valid", bus.done_valid_out, 1);
        end
        bus.done_ready_in = 1'b1;
        drain();
        repeat (15) @(posedge clk_in);
        #1;
        chk("stall_single_result", n_res - res0, 1);
        chk("stall_idle_after", bus.busy_out, 0);

        // Asynchronous reset in the middle of CALC
        send(8'h33, 8'h55, 1'b0, model(8'h33, 8'h55, 1'b0), t0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.count_out == 4) seen = 1'b1;
            else begin @(posedge clk_in); #1; end
        end
        chk("reached_iter4", seen, 1);
        #3 rst_n_in = 1'b0;
        exp_q.delete();
        t_q.delete();
        #1;
        chk("midrst_product", bus.product_out, 0);
        chk("midrst_count", bus.count_out, 0);
        chk("midrst_done_valid", bus.done_valid_out, 0);
        chk("midrst_busy", bus.busy_out, 0);
        @(posedge clk_in); #2 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        chk("midrst_start_ready", bus.start_ready_out, 1);
        lat_check = 1'b1;
        send(8'd7, 8'd6, 1'b0, 16'h002A, t0);
        drain();

        // Back-to-back with start_valid and done_ready held high
        send(tbl[0].a, tbl[0].b, tbl[0].s, tbl[0].p, t0);
        for (int i = 1; i < 6; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, t1);
`ifndef BOOTH_EARLY_TERM_EN
            chk("b2b_interval", t1 - t0, 11);
`endif
            t0 = t1;
        end
        drain();

`ifdef BOOTH_EARLY_TERM_EN
        lat_check = 1'b0;
        send(8'd5, 8'd0, 1'b0, 16'h0000, t0);
        drain();
        chk("early_b0_latency", last_lat, 2);
        send(8'd5, 8'd1, 1'b0, 16'h0005, t0);
        drain();
        chk("early_b1_latency_lt10", (last_lat < 10), 1);
`endif

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs), t0);
        end
        drain();

        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Parametrised sequential radix-2 Booth multiplier with valid/ready handshakes on both operand and result sides. Each transaction selects signed or unsigned operands. The block replaces the fixed-width, free-running-counter multiplier/FSM pair as the shared multiply engine. It accepts one operation at a time and holds its result until the consumer accepts it.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `CNT_W`, derived localparam, value `$clog2(WIDTH+2)`: iteration counter width; not overridable.
- `clk_in`, input, 1: clock; all state is updated on the rising edge.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `start_valid_in`, input, 1: operand bundle valid.
- `start_ready_out`, output, 1: block can accept operands; high only in IDLE.
- `multiplicand_in`, input, WIDTH: operand A.
- `multiplier_in`, input, WIDTH: operand B.
- `signed_in`, input, 1: 1 means both operands are two's complement; 0 means both are unsigned.
- `product_out`, output, 2*WIDTH: result A*B. Signed result for signed operations, unsigned result otherwise.
- `done_valid_out`, output, 1: `product_out` is valid; high only in DONE.
- `done_ready_in`, input, 1: consumer accepts the result.
- `busy_out`, output, 1: high in CALC or DONE.
- `count_out`, output, CNT_W: number of Booth iterations completed for the current operation.

## Operation
- States:
  - IDLE: `start_ready_out`=1.
  - CALC: one Booth iteration per cycle.
  - DONE: result held.
- IDLE→CALC on `start_valid_in & start_ready_out`.
  - Operands are extended to WIDTH+1 bits: sign-extended if `signed_in`=1, zero-extended otherwise.
  - Registers loaded: M ← ext(A); Q ← ext(B); Acc ← 0; q_m1 ← 0; count ← 0.
- CALC iteration, on bits {Q[0], q_m1}:
  - 01: Acc += M.
  - 10: Acc −= M.
  - 00 or 11: no add.
  - Then arithmetic shift right of {Acc, Q, q_m1} by 1, and count += 1.
  - Acc arithmetic is WIDTH+1 bits and wraps modulo 2^(WIDTH+1). This is correct by construction.
- CALC→DONE after the iteration that makes count == WIDTH+1. At that transition, `product_out` ← low 2*WIDTH bits of {Acc, Q}.
- DONE→IDLE on `done_ready_in`=1. `product_out` keeps its value after leaving DONE until the next load into DONE.
- `start_valid_in` is ignored outside IDLE; the operand inputs are not sampled. `done_ready_in` is ignored outside DONE.
- There is no same-cycle DONE→accept bypass. The next operation is accepted no earlier than the cycle after the result handshake.
- Reset values, with `rst_n_in` low at any time, including mid-operation:
  - State returns to IDLE immediately; any in-flight operation is aborted with no result.
  - `product_out`=0, `count_out`=0, `done_valid_out`=0, `busy_out`=0.
  - `start_ready_out`=1 once reset is released.

## Timing
- Acceptance edge is T.
- CALC occupies cycles T+1 .. T+WIDTH+1 (WIDTH+1 cycles).
- `done_valid_out` rises after edge T+WIDTH+2. For WIDTH=8, this is 10 edges after acceptance.
- Maximum throughput is one operation per WIDTH+3 cycles when `done_ready_in` is held at 1.
- All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- `product_out` is stable while `done_valid_out`=1 and `done_ready_in`=0, for an indefinite stall.

## Configuration
- `BOOTH_EARLY_TERM_EN` defined:
  - In CALC, condition X is: the unprocessed bits Q[WIDTH+1−count−1 .. 0] and q_m1 are all equal.
  - When X is true, the remaining iterations would be shift-only. The block transitions to DONE in that same cycle.
  - In that case, the result is {Acc, Q} arithmetic-shifted right by (WIDTH+1−count), truncated to 2*WIDTH bits.
  - `count_out` freezes at its value before termination.
  - Minimum latency: `done_valid_out` rises after edge T+2, for example when B=0.
- `BOOTH_EARLY_TERM_EN` undefined: latency is always fixed as given in Timing, and the shifter logic is absent.

## Structure
- Shared package `booth_pkg` holds:
  - `booth_state_t` enum (IDLE, CALC, DONE).
  - Function `booth_cnt_w(width)`.
  - Encoding constants for the Booth bit-pair actions (NOP/ADD/SUB).
- One sub-module, `booth_step`: combinational single iteration.
  - Inputs: Acc, Q, q_m1, M.
  - Outputs: next Acc, Q, q_m1.
  - Parametrised by WIDTH.
- The top level contains the FSM, counter, registers, and handshake logic.

## Test plan
All cases use WIDTH=8 unless stated.
- Unsigned 255*255 (`signed_in`=0) → `product_out`=0xFE01; `done_valid_out` rises exactly 10 edges after acceptance; `count_out`=9.
- Signed −128 * −128 (0x80, 0x80, `signed_in`=1) → 0x4000. Signed −1 * 1 → 0xFFFF.
- Unsigned 200*3 → 0x0258. Hold `done_ready_in`=0 for 20 cycles: `product_out` stays stable, `start_ready_out`=0, and a new `start_valid_in` pulse is ignored.
- Deassert `rst_n_in` asynchronously at CALC iteration 4 → outputs go to 0 immediately and state is IDLE. A later 7*6 operation returns 0x002A with nominal latency.
- Back-to-back: `done_ready_in`=1 and `start_valid_in`=1 held constant with operand streams → one acceptance every 11 cycles.
- With `BOOTH_EARLY_TERM_EN`: B=0 → `done_valid_out` after edge T+2 with product 0. B=1, A=5, unsigned → 0x0005 with latency below 10. Randomized signed/unsigned results match a reference model for WIDTH=2, 8 and 16.
